active_list: RTL and testbench
==============================

Name: active_list

Overview:
- In-order retirement buffer on the receiving end of the rename stage's previous-mapping pairing.
- Each renamed destination writes an entry holding logical reg, previous physical reg and newly allocated physical reg.
- Entries retire in program order once marked complete; the previous physical reg of each retired entry returns to the rename free list.
- On a flush, entries are walked back youngest-first, restoring map-table mappings and freeing squashed allocations.

Parameters:
DEPTH, 32, number of entries (power of two)
IDX_W, 5, log2(DEPTH)
PHYS_W, 6, physical register index width (64 physical regs)
LOG_W, 5, logical register index width (32 MIPS regs)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alloc_valid  in  1  rename presents an entry
alloc_ready  out  1  entry accepted this cycle when alloc_valid
alloc_logical  in  LOG_W  prev_logical_reg from rename
alloc_prev_phys  in  PHYS_W  prev_physical_reg from rename
alloc_new_phys  in  PHYS_W  newly allocated physical reg
alloc_index  out  IDX_W  tag of entry being allocated (current tail)
complete_valid  in  1  execution finished for an entry
complete_index  in  IDX_W  tag being completed
flush_valid  in  1  squash request
flush_index  in  IDX_W  oldest tag to squash
free_valid  out  1  free_register returns to free list
free_register  out  PHYS_W  physical reg to free
restore_valid  out  1  map-table restore write
restore_logical  out  LOG_W  logical reg to restore
restore_phys  out  PHYS_W  mapping to restore
recovering  out  1  FSM in RECOVER
count  out  IDX_W+1  occupied entries

Behaviour:
- Storage: head, tail (IDX_W, wrap modulo DEPTH), count (IDX_W+1), per-entry valid/done/logical/prev_phys/new_phys.
- Reset: head=tail=0, count=0, all valid/done=0, FSM=RUN; free_valid, restore_valid, recovering = 0; free_register, restore_logical, restore_phys = 0.
- Reset mid-RECOVER aborts the walk; no further outputs are issued.
- alloc_ready = (state==RUN) && (count<DEPTH) && !flush_valid.
- alloc_index = tail (combinational).
- Allocation when alloc_valid && alloc_ready: write entry at tail with valid=1, done=0; tail++.
- Completion: when complete_valid and entry[complete_index].valid, set done=1 next cycle. Ignored otherwise. Accepted in both states.
- Commit, RUN only, not in a flush cycle:
  - Condition: count>0 && entry[head].valid && entry[head].done.
  - Action: clear valid; head++; next cycle free_valid=1, free_register=prev_phys.
  - Maximum one commit per cycle.
  - count updates net of simultaneous alloc and commit.
- Flush, RUN only:
  - Legal when flush_index lies in circular range [head, tail).
  - flush_index==tail, or outside the range: ignored, no state change.
  - Legal flush: commit and alloc suppressed that cycle; stop=flush_index latched; go to RECOVER.
  - flush_valid during RECOVER is ignored.
- RECOVER, one entry per cycle, starting with e=tail-1:
  - Clear entry[e].valid/done; tail=e; count--.
  - Next cycle: restore_valid=1, restore_logical=logical, restore_phys=prev_phys, free_valid=1, free_register=new_phys.
  - When e==stop, return to RUN after this step.
  - Squashing N entries takes N cycles; alloc_ready returns the cycle after the last step.
- Registered outputs are single-cycle pulses. Zero-valued data is held when the matching valid is low.
- free_valid sources (commit, squash) are mutually exclusive by construction.
- Full: count==DEPTH, so alloc_ready=0 and commits continue. Empty: count==0, no commit.
- Pointer wrap from DEPTH-1 to 0 is seamless for alloc, commit and squash.

Test Plan:
- Reset, then alloc 3 entries (L=4/prev=4/new=32, L=5/prev=5/new=33, L=4/prev=32/new=34) -> alloc_index 0,1,2; count=3; no free_valid.
- Complete idx1, then idx0 -> cycle after idx0's done: free_register=4; next cycle free_register=5; count=1. Idx2 not committed until completed.
- Fill 32 entries -> alloc_ready=0 at count=32. Complete idx0 -> one commit, alloc_ready=1. Next alloc gets alloc_index=0 (wrap).
- 5 entries at tags 0..4, flush_index=2 -> 3 cycles of restore pulses, youngest first: tags 4,3,2 (restore_phys=prev_phys, free_register=new_phys). recovering high 3 cycles; tail=2; count=2.
- Flush with alloc_valid and a ready-to-commit head in the same cycle -> neither alloc nor commit happens. Second flush_valid during RECOVER is ignored.
- flush_index==tail, or complete on an unallocated tag -> no state change. rst asserted mid-RECOVER -> next cycle count=0, all valid outputs low.

Source files
------------

// File: rtl/active_list.sv
`default_nettype none
// ============================================================================
// active_list : in-order retirement buffer with youngest-first flush walk-back
// Rev 1.0
// ============================================================================
module active_list #(
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5,
  parameter int PHYS_W = 6,
  parameter int LOG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [LOG_W-1:0]  alloc_logical,
  input  logic [PHYS_W-1:0] alloc_prev_phys,
  input  logic [PHYS_W-1:0] alloc_new_phys,
  output logic [IDX_W-1:0]  alloc_index,
  input  logic              complete_valid,
  input  logic [IDX_W-1:0]  complete_index,
  input  logic              flush_valid,
  input  logic [IDX_W-1:0]  flush_index,
  output logic              free_valid,
  output logic [PHYS_W-1:0] free_register,
  output logic              restore_valid,
  output logic [LOG_W-1:0]  restore_logical,
  output logic [PHYS_W-1:0] restore_phys,
  output logic              recovering,
  output logic [IDX_W:0]    count
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  state_t state, state_next;

  logic [IDX_W-1:0]  head, tail, stop;
  logic [DEPTH-1:0]  ent_valid, ent_done;
  logic [LOG_W-1:0]  ent_logical [DEPTH];
  logic [PHYS_W-1:0] ent_prev    [DEPTH];
  logic [PHYS_W-1:0] ent_new     [DEPTH];

  logic [IDX_W-1:0] flush_off, walk_idx;
  logic             flush_legal, do_flush, do_alloc, do_commit, do_squash, walk_last;

  assign alloc_index = tail;
  assign recovering  = (state == ST_RECOVER);

  always_comb begin
    // Offset from head is compared against occupancy so a full ring (head==tail)
    // still treats every tag as in range.
    flush_off   = flush_index - head;
    flush_legal = ({1'b0, flush_off} < count);
    do_flush    = (state == ST_RUN) && flush_valid && flush_legal;
    alloc_ready = (state == ST_RUN) && (count < FULL) && !flush_valid;
    do_alloc    = alloc_valid && alloc_ready;
    do_commit   = (state == ST_RUN) && !do_flush && (count != '0) &&
                  ent_valid[head] && ent_done[head];
    do_squash   = (state == ST_RECOVER);
    walk_idx    = tail - 1'b1;
    walk_last   = (walk_idx == stop);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:     if (do_flush) state_next = ST_RECOVER;
      ST_RECOVER: if (walk_last) state_next = ST_RUN;
      default:    state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_RUN;
      head            <= '0;
      tail            <= '0;
      stop            <= '0;
      count           <= '0;
      ent_valid       <= '0;
      ent_done        <= '0;
      free_valid      <= 1'b0;
      free_register   <= '0;
      restore_valid   <= 1'b0;
      restore_logical <= '0;
      restore_phys    <= '0;
    end else begin
      state           <= state_next;
      free_valid      <= 1'b0;
      free_register   <= '0;
      restore_valid   <= 1'b0;
      restore_logical <= '0;
      restore_phys    <= '0;

      if (complete_valid && ent_valid[complete_index]) begin
        ent_done[complete_index] <= 1'b1;
      end

      if (do_alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        tail            <= tail + 1'b1;
      end

      if (do_commit) begin
        ent_valid[head] <= 1'b0;
        ent_done[head]  <= 1'b0;
        head            <= head + 1'b1;
        free_valid      <= 1'b1;
        free_register   <= ent_prev[head];
      end

      if (do_flush) begin
        stop <= flush_index;
      end

      // Squash clears come last so they override a same-cycle completion.
      if (do_squash) begin
        ent_valid[walk_idx] <= 1'b0;
        ent_done[walk_idx]  <= 1'b0;
        tail                <= walk_idx;
        restore_valid       <= 1'b1;
        restore_logical     <= ent_logical[walk_idx];
        restore_phys        <= ent_prev[walk_idx];
        free_valid          <= 1'b1;
        free_register       <= ent_new[walk_idx];
      end

      if (do_squash) begin
        count <= count - 1'b1;
      end else if (do_alloc && !do_commit) begin
        count <= count + 1'b1;
      end else if (do_commit && !do_alloc) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) begin
      ent_logical[tail] <= alloc_logical;
      ent_prev[tail]    <= alloc_prev_phys;
      ent_new[tail]     <= alloc_new_phys;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_active_list.sv
`default_nettype none
// ============================================================================
// tb_active_list : scoreboard bench for active_list free/restore traffic
// Rev 1.0
// ============================================================================
module tb_active_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [4:0] alloc_logical;
  logic [5:0] alloc_prev_phys;
  logic [5:0] alloc_new_phys;
  logic [4:0] alloc_index;
  logic       complete_valid;
  logic [4:0] complete_index;
  logic       flush_valid;
  logic [4:0] flush_index;
  logic       free_valid;
  logic [5:0] free_register;
  logic       restore_valid;
  logic [4:0] restore_logical;
  logic [5:0] restore_phys;
  logic       recovering;
  logic [5:0] count;

  active_list #(.DEPTH(32), .IDX_W(5), .PHYS_W(6), .LOG_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_logical   (alloc_logical),
    .alloc_prev_phys (alloc_prev_phys),
    .alloc_new_phys  (alloc_new_phys),
    .alloc_index     (alloc_index),
    .complete_valid  (complete_valid),
    .complete_index  (complete_index),
    .flush_valid     (flush_valid),
    .flush_index     (flush_index),
    .free_valid      (free_valid),
    .free_register   (free_register),
    .restore_valid   (restore_valid),
    .restore_logical (restore_logical),
    .restore_phys    (restore_phys),
    .recovering      (recovering),
    .count           (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rv;
    logic [4:0] rl;
    logic [5:0] rp;
    logic       fv;
    logic [5:0] fr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_free(input logic [5:0] fr);
    sb.push_back('{rv: 1'b0, rl: 5'd0, rp: 6'd0, fv: 1'b1, fr: fr});
  endtask

  task automatic push_squash(input logic [4:0] rl, input logic [5:0] rp, input logic [5:0] fr);
    sb.push_back('{rv: 1'b1, rl: rl, rp: rp, fv: 1'b1, fr: fr});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] l, input logic [5:0] p, input logic [5:0] n,
                       input int exp_idx);
    alloc_valid     = 1'b1;
    alloc_logical   = l;
    alloc_prev_phys = p;
    alloc_new_phys  = n;
    #1;
    chk("alloc_ready", alloc_ready, 1);
    chk("alloc_index", alloc_index, exp_idx);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic complete(input logic [4:0] idx);
    complete_valid = 1'b1;
    complete_index = idx;
    tick();
    complete_valid = 1'b0;
  endtask

  // Monitor: every free/restore pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (free_valid === 1'b1 || restore_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: free_valid=%0d free_register=%0d restore_valid=%0d restore_phys=%0d, expected no pulse at %0t",
                 free_valid, free_register, restore_valid, restore_phys, $time);
      end else begin
        e = sb.pop_front();
        chk("mon_restore_valid",   restore_valid,   e.rv);
        chk("mon_restore_logical", restore_logical, e.rl);
        chk("mon_restore_phys",    restore_phys,    e.rp);
        chk("mon_free_valid",      free_valid,      e.fv);
        chk("mon_free_register",   free_register,   e.fr);
      end
    end
  end

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_logical = '0; alloc_prev_phys = '0; alloc_new_phys = '0;
    complete_valid = 1'b0; complete_index = '0;
    flush_valid = 1'b0; flush_index = '0;
    do_reset();

    chk("rst_count",         count, 0);
    chk("rst_alloc_ready",   alloc_ready, 1);
    chk("rst_alloc_index",   alloc_index, 0);
    chk("rst_free_valid",    free_valid, 0);
    chk("rst_restore_valid", restore_valid, 0);
    chk("rst_recovering",    recovering, 0);

    // Three allocations, out-of-order completion, in-order retirement.
    alloc(5'd4, 6'd4,  6'd32, 0);
    alloc(5'd5, 6'd5,  6'd33, 1);
    alloc(5'd4, 6'd32, 6'd34, 2);
    chk("alloc3_count", count, 3);
    complete(5'd1);
    tick();
    chk("idx1_only_count", count, 3);
    push_free(6'd4);
    push_free(6'd5);
    complete(5'd0);
    tick();
    chk("commit0_count", count, 2);
    tick();
    chk("commit1_count", count, 1);
    repeat (3) tick();
    chk("idx2_held_count", count, 1);
    push_free(6'd32);
    complete(5'd2);
    repeat (3) tick();
    chk("drained_count", count, 0);

    // Fill to full, commit while full, wrap the tail.
    do_reset();
    for (int i = 0; i < 32; i++) alloc(5'(i), 6'(i), 6'(32 + i), i);
    chk("full_count", count, 32);
    chk("full_alloc_ready", alloc_ready, 0);
    push_free(6'd0);
    complete(5'd0);
    tick();
    chk("after_full_commit_count", count, 31);
    chk("after_full_commit_ready", alloc_ready, 1);
    alloc(5'd7, 6'd9, 6'd10, 0);
    chk("refill_count", count, 32);
    push_free(6'd1);
    complete(5'd1);
    tick();
    chk("full_commit2_count", count, 31);
    tick();

    // Flush with simultaneous alloc and ready head; second flush during walk.
    do_reset();
    for (int t = 0; t < 5; t++) alloc(5'(10 + t), 6'(20 + t), 6'(40 + t), t);
    complete(5'd0);
    flush_valid = 1'b1; flush_index = 5'd2;
    alloc_valid = 1'b1; alloc_logical = 5'd1; alloc_prev_phys = 6'd1; alloc_new_phys = 6'd1;
    #1;
    chk("flush_cycle_alloc_ready", alloc_ready, 0);
    push_squash(5'd14, 6'd24, 6'd44);
    push_squash(5'd13, 6'd23, 6'd43);
    push_squash(5'd12, 6'd22, 6'd42);
    push_free(6'd20);
    tick();
    alloc_valid = 1'b0;
    flush_index = 5'd0;
    chk("rec1_recovering", recovering, 1);
    chk("rec1_count", count, 5);
    chk("rec1_alloc_index", alloc_index, 5);
    tick();
    flush_valid = 1'b0;
    chk("rec2_recovering", recovering, 1);
    chk("rec2_count", count, 4);
    tick();
    chk("rec3_recovering", recovering, 1);
    chk("rec3_count", count, 3);
    tick();
    chk("rec_done_recovering", recovering, 0);
    chk("rec_done_count", count, 2);
    chk("rec_done_alloc_ready", alloc_ready, 1);
    chk("rec_done_tail", alloc_index, 2);
    tick();
    chk("post_flush_commit_count", count, 1);

    // Ignored flushes and a completion to an unallocated tag.
    flush_valid = 1'b1; flush_index = 5'd2;
    tick();
    chk("flush_tail_ignored", recovering, 0);
    flush_index = 5'd9;
    tick();
    flush_valid = 1'b0;
    chk("flush_out_ignored", recovering, 0);
    chk("flush_out_count", count, 1);
    chk("flush_out_tail", alloc_index, 2);
    complete(5'd3);
    tick();
    chk("unalloc_complete_count", count, 1);

    // Reset in the middle of a recovery walk.
    alloc(5'd1, 6'd50, 6'd60, 2);
    alloc(5'd2, 6'd51, 6'd61, 3);
    alloc(5'd3, 6'd52, 6'd62, 4);
    chk("pre_rst_count", count, 4);
    push_squash(5'd3, 6'd52, 6'd62);
    flush_valid = 1'b1; flush_index = 5'd2;
    tick();
    flush_valid = 1'b0;
    chk("mid_rec_recovering", recovering, 1);
    tick();
    chk("mid_rec_count", count, 3);
    rst = 1'b1;
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_free_valid", free_valid, 0);
    chk("mid_rst_restore_valid", restore_valid, 0);
    chk("mid_rst_recovering", recovering, 0);
    rst = 1'b0;
    repeat (4) tick();
    chk("post_rst_count", count, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
